// File: rtl/lcd_text_writer.sv
// +-----------------------------------------------------------------------------
// | Module      : lcd_text_writer
// | Description : 2x16 character frame buffer streamed to a character-LCD
// |               controller as address commands and character bytes.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module lcd_text_writer #(
    parameter logic [7:0] LINE0_CMD    = 8'h80,
    parameter logic [7:0] LINE1_CMD    = 8'hC0,
    parameter bit         AUTO_REFRESH = 1'b0,
    parameter logic [7:0] FILL_CHAR    = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       refresh_req,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] ctrl_data,
    output logic       ctrl_rs,
    output logic       ctrl_strobe,
    input  logic       ctrl_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_t;

    localparam logic [5:0] c_LAST_IDX  = 6'd33;
    localparam logic [5:0] c_LINE1_IDX = 6'd17;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       strobe_q, strobe_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       dirty_q, dirty_d;
    logic       pending_q, pending_d;
    logic [7:0] buf_q [32];
    logic [7:0] buf_d [32];

    logic       w_start;
    logic [4:0] w_char_addr;

    assign w_start = (state_q == IDLE) && ctrl_done &&
                     (refresh_req || pending_q || (AUTO_REFRESH && dirty_q));

    // Modulo-32 subtraction maps idx 1..16 to 0..15 and idx 18..33 to 16..31.
    assign w_char_addr = (idx_q <= 6'd16) ? (idx_q[4:0] - 5'd1) : (idx_q[4:0] - 5'd2);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        strobe_d     = 1'b0;
        rs_d         = rs_q;
        data_d       = data_q;
        dirty_d      = dirty_q;
        pending_d    = pending_q;
        rd_data_d    = buf_q[rd_addr];
        buf_d        = buf_q;

        if (wr_en) begin
            buf_d[wr_addr] = wr_data;
        end

        if (w_start) begin
            dirty_d   = 1'b0;
            pending_d = 1'b0;
        end else if (refresh_req) begin
            pending_d = 1'b1;
        end
        // A write in the frame-start cycle keeps the buffer marked dirty.
        if (wr_en) begin
            dirty_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (w_start) begin
                    idx_d   = 6'd0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                strobe_d = 1'b1;
                if (idx_q == 6'd0) begin
                    data_d = LINE0_CMD;
                    rs_d   = 1'b0;
                end else if (idx_q == c_LINE1_IDX) begin
                    data_d = LINE1_CMD;
                    rs_d   = 1'b0;
                end else begin
                    data_d = buf_q[w_char_addr];
                    rs_d   = 1'b1;
                end
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!ctrl_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (ctrl_done) begin
                    if (idx_q == c_LAST_IDX) begin
                        frame_done_d = 1'b1;
                        state_d      = FINISH;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = SEND;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 6'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            strobe_q     <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            rd_data_q    <= 8'h00;
            dirty_q      <= 1'b0;
            pending_q    <= 1'b0;
            buf_q        <= '{default: FILL_CHAR};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            strobe_q     <= strobe_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            rd_data_q    <= rd_data_d;
            dirty_q      <= dirty_d;
            pending_q    <= pending_d;
            buf_q        <= buf_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign ctrl_data   = data_q;
    assign ctrl_rs     = rs_q;
    assign ctrl_strobe = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_writer.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_lcd_text_writer
// | Description : Bench for lcd_text_writer; two instances (manual / auto refresh).
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_lcd_text_writer;

    localparam logic [7:0] c_LINE0 = 8'h80;
    localparam logic [7:0] c_LINE1 = 8'hC0;
    localparam logic [7:0] c_FILL  = 8'h20;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       wr_en0, refresh_req0, busy0, frame_done0, ctrl_rs0, ctrl_strobe0;
    logic [4:0] wr_addr0, rd_addr0;
    logic [7:0] wr_data0, rd_data0, ctrl_data0;
    logic       ctrl_done0 = 1'b1;
    logic       wr_en1, refresh_req1, busy1, frame_done1, ctrl_rs1, ctrl_strobe1;
    logic [4:0] wr_addr1, rd_addr1;
    logic [7:0] wr_data1, rd_data1, ctrl_data1;
    logic       ctrl_done1 = 1'b1;

    lcd_text_writer #(.AUTO_REFRESH(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .refresh_req(refresh_req0), .busy(busy0),
        .frame_done(frame_done0), .ctrl_data(ctrl_data0), .ctrl_rs(ctrl_rs0),
        .ctrl_strobe(ctrl_strobe0), .ctrl_done(ctrl_done0));

    lcd_text_writer #(.AUTO_REFRESH(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .refresh_req(refresh_req1), .busy(busy1),
        .frame_done(frame_done1), .ctrl_data(ctrl_data1), .ctrl_rs(ctrl_rs1),
        .ctrl_strobe(ctrl_strobe1), .ctrl_done(ctrl_done1));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit hold0 = 1'b0;
    int lat0 = 0, lat1 = 0;

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    logic [8:0] q0[$], q1[$];
    int         sc0[$], fdc0[$];
    int         fd0 = 0, fd1 = 0;

    // Controller model: drops done the cycle after a strobe, stays busy 1..4 cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ctrl_strobe0) begin
            ctrl_done0 <= 1'b0;
            lat0 <= $urandom_range(1, 4);
        end else if (lat0 > 0) lat0 <= lat0 - 1;
        else ctrl_done0 <= !hold0;
        if (ctrl_strobe1) begin
            ctrl_done1 <= 1'b0;
            lat1 <= $urandom_range(1, 4);
        end else if (lat1 > 0) lat1 <= lat1 - 1;
        else ctrl_done1 <= 1'b1;
    end

    always @(negedge clk) begin
        if (ctrl_strobe0) begin
            q0.push_back({ctrl_rs0, ctrl_data0});
            sc0.push_back(cyc);
        end
        if (frame_done0) begin
            fd0++;
            fdc0.push_back(cyc);
        end
        if (ctrl_strobe1) q1.push_back({ctrl_rs1, ctrl_data1});
        if (frame_done1) fd1++;
    end

    // Reference: byte k of a frame built from the modelled 2x16 buffer.
    function automatic logic [8:0] exp_byte(input int k, input bit which);
        logic [7:0] ch;
        if (k == 0) return {1'b0, c_LINE0};
        if (k == 17) return {1'b0, c_LINE1};
        ch = (k < 17) ? (which ? mem1[k-1] : mem0[k-1]) : (which ? mem1[k-2] : mem0[k-2]);
        return {1'b1, ch};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = c_FILL;
            mem1[i] = c_FILL;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write0(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en0 = 1'b1; wr_addr0 = a; wr_data0 = d; mem0[a] = d;
        @(negedge clk);
        wr_en0 = 1'b0;
    endtask

    task automatic pulse_req0(output int c);
        @(negedge clk);
        refresh_req0 = 1'b1; c = cyc;
        @(negedge clk);
        refresh_req0 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy0, frame_done0, ctrl_strobe0, ctrl_rs0} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 0000", {busy0, frame_done0, ctrl_strobe0, ctrl_rs0});
        end
        vectors++;
        if ({ctrl_data0, rd_data0} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data: got ctrl_data=%02h rd_data=%02h, expected 00 00", ctrl_data0, rd_data0);
        end
        for (int i = 0; i < 4; i++) begin
            automatic logic [4:0] a = 5'($urandom);
            rd_addr0 = a;
            @(negedge clk);
            vectors++;
            if (rd_data0 !== mem0[a]) begin
                miscompares++;
                $display("FAIL reset_readback[%0d]: got %02h, expected %02h", a, rd_data0, mem0[a]);
            end
        end
    endtask

    task automatic test_default_frame();
        int base, bf, rc, bad;
        base = q0.size(); bf = fd0;
        pulse_req0(rc);
        for (int i = 0; i < 3000 && fd0 < bf + 1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        vectors++;
        if (fd0 != bf + 1 || q0.size() != base + 34) begin
            miscompares++;
            $display("FAIL default_frame_len: got %0d bytes %0d done pulses, expected 34 and 1", q0.size() - base, fd0 - bf);
        end else begin
            for (int k = 0; k < 34; k++) begin
                automatic logic [8:0] e = exp_byte(k, 1'b0);
                vectors++;
                if (q0[base+k] !== e) begin
                    miscompares++;
                    $display("FAIL default_byte[%0d]: got %03h, expected %03h", k, q0[base+k], e);
                end
            end
            vectors++;
            if (sc0[base] != rc + 2) begin
                miscompares++;
                $display("FAIL first_strobe_latency: got %0d, expected 2", sc0[base] - rc);
            end
            bad = 0;
            for (int k = 1; k < 34; k++) if (sc0[base+k] - sc0[base+k-1] < 4) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL strobe_spacing: got %0d gaps under 4, expected 0", bad);
            end
        end
        vectors++;
        if (busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_frame: got %b, expected 0", busy0);
        end
    endtask

    task automatic test_writes();
        int base, bf, rc;
        for (int i = 0; i < 6; i++) write0(5'($urandom), 8'($urandom_range(8'h21, 8'h7E)));
        write0(5'd0, 8'h41);
        write0(5'd31, 8'h5A);
        base = q0.size(); bf = fd0;
        pulse_req0(rc);
        for (int i = 0; i < 3000 && fd0 < bf + 1; i++) @(negedge clk);
        vectors++;
        if (q0.size() != base + 34) begin
            miscompares++;
            $display("FAIL write_frame_len: got %0d bytes, expected 34", q0.size() - base);
        end else begin
            for (int k = 0; k < 34; k++) begin
                automatic logic [8:0] e = exp_byte(k, 1'b0);
                vectors++;
                if (q0[base+k] !== e) begin
                    miscompares++;
                    $display("FAIL write_byte[%0d]: got %03h, expected %03h", k, q0[base+k], e);
                end
            end
            vectors++;
            if (q0[base+1] !== 9'h141 || q0[base+33] !== 9'h15A) begin
                miscompares++;
                $display("FAIL write_ends: got %03h %03h, expected 141 15a", q0[base+1], q0[base+33]);
            end
        end
        rd_addr0 = 5'd31;
        @(negedge clk);
        vectors++;
        if (rd_data0 !== 8'h5A) begin
            miscompares++;
            $display("FAIL readback_31: got %02h, expected 5a", rd_data0);
        end
    endtask

    task automatic test_ctrl_init();
        int base, bf, rc, rel;
        hold0 = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        base = q0.size(); bf = fd0;
        pulse_req0(rc);
        repeat (1000) @(negedge clk);
        vectors++;
        if (q0.size() != base || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL init_hold: got %0d strobes busy=%b, expected 0 strobes busy=0", q0.size() - base, busy0);
        end
        hold0 = 1'b0; rel = cyc;
        for (int i = 0; i < 3000 && fd0 < bf + 1; i++) @(negedge clk);
        vectors++;
        if (q0.size() != base + 34) begin
            miscompares++;
            $display("FAIL init_frame_len: got %0d bytes, expected 34", q0.size() - base);
        end else begin
            vectors++;
            if (sc0[base] - rel > 3 || sc0[base] - rel < 1) begin
                miscompares++;
                $display("FAIL init_release_latency: got %0d cycles, expected 1..3", sc0[base] - rel);
            end
            for (int k = 0; k < 34; k++) begin
                automatic logic [8:0] e = exp_byte(k, 1'b0);
                vectors++;
                if (q0[base+k] !== e) begin
                    miscompares++;
                    $display("FAIL init_byte[%0d]: got %03h, expected %03h", k, q0[base+k], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, bf, rc;
        for (int i = 0; i < 4; i++) write0(5'($urandom), 8'($urandom));
        base = q0.size(); bf = fd0;
        pulse_req0(rc);
        for (int i = 0; i < 500 && q0.size() < base + 5; i++) @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            pulse_req0(rc);
            repeat (7) @(negedge clk);
        end
        for (int i = 0; i < 6000 && fd0 < bf + 2; i++) @(negedge clk);
        repeat (500) @(negedge clk);
        vectors++;
        if (fd0 != bf + 2 || q0.size() != base + 68) begin
            miscompares++;
            $display("FAIL merge_count: got %0d frames %0d bytes, expected 2 frames 68 bytes", fd0 - bf, q0.size() - base);
        end else begin
            vectors++;
            if (sc0[base+34] - fdc0[bf] > 3) begin
                miscompares++;
                $display("FAIL merge_restart_gap: got %0d cycles, expected <= 3", sc0[base+34] - fdc0[bf]);
            end
            for (int k = 0; k < 68; k++) begin
                automatic logic [8:0] e = exp_byte(k % 34, 1'b0);
                vectors++;
                if (q0[base+k] !== e) begin
                    miscompares++;
                    $display("FAIL merge_byte[%0d]: got %03h, expected %03h", k, q0[base+k], e);
                end
            end
        end
    endtask

    task automatic test_auto_refresh();
        int base, bf;
        base = q1.size(); bf = fd1;
        @(negedge clk); refresh_req1 = 1'b1;
        @(negedge clk); refresh_req1 = 1'b0;
        for (int i = 0; i < 500 && q1.size() < base + 10; i++) @(negedge clk);
        @(negedge clk);
        wr_en1 = 1'b1; wr_addr1 = 5'd20; wr_data1 = 8'h33; mem1[20] = 8'h33;
        @(negedge clk);
        wr_en1 = 1'b0;
        for (int i = 0; i < 6000 && fd1 < bf + 2; i++) @(negedge clk);
        repeat (500) @(negedge clk);
        vectors++;
        if (fd1 != bf + 2 || q1.size() != base + 68) begin
            miscompares++;
            $display("FAIL auto_count: got %0d frames %0d bytes, expected 2 frames 68 bytes", fd1 - bf, q1.size() - base);
        end else begin
            vectors++;
            if (q1[base+22] !== 9'h133 || q1[base+56] !== 9'h133) begin
                miscompares++;
                $display("FAIL auto_byte23: got %03h %03h, expected 133 133", q1[base+22], q1[base+56]);
            end
            for (int k = 0; k < 68; k++) begin
                automatic logic [8:0] e = exp_byte(k % 34, 1'b1);
                vectors++;
                if (q1[base+k] !== e) begin
                    miscompares++;
                    $display("FAIL auto_byte[%0d]: got %03h, expected %03h", k, q1[base+k], e);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base, nb, rc;
        logic [4:0] addrs [3];
        for (int i = 0; i < 3; i++) begin
            addrs[i] = 5'($urandom);
            write0(addrs[i], 8'h41 + 8'(i));
        end
        base = q0.size();
        pulse_req0(rc);
        for (int i = 0; i < 500 && q0.size() < base + 10; i++) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = c_FILL;
            mem1[i] = c_FILL;
        end
        @(negedge clk);
        vectors++;
        if ({busy0, frame_done0, ctrl_strobe0, ctrl_rs0, ctrl_data0} !== 12'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got busy=%b fd=%b stb=%b rs=%b data=%02h, expected all 0",
                     busy0, frame_done0, ctrl_strobe0, ctrl_rs0, ctrl_data0);
        end
        rst = 1'b0;
        nb = q0.size();
        repeat (60) @(negedge clk);
        vectors++;
        if (q0.size() != nb || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d strobes busy=%b, expected 0 strobes busy=0", q0.size() - nb, busy0);
        end
        for (int i = 0; i < 3; i++) begin
            rd_addr0 = addrs[i];
            @(negedge clk);
            vectors++;
            if (rd_data0 !== mem0[addrs[i]]) begin
                miscompares++;
                $display("FAIL midreset_readback[%0d]: got %02h, expected %02h", addrs[i], rd_data0, mem0[addrs[i]]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; rd_addr0 = '0; refresh_req0 = 1'b0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; rd_addr1 = '0; refresh_req1 = 1'b0;
        test_reset();
        test_default_frame();
        test_writes();
        test_ctrl_init();
        test_back_to_back();
        test_auto_refresh();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/lcd_text_writer.md
Name: lcd_text_writer

Overview:
- Upstream feeder for the character LCD controller: holds a 2x16 character frame buffer and streams it to the controller as a byte sequence.
- Each frame is sent in this order: line-0 DDRAM address command, 16 characters, line-1 DDRAM address command, 16 characters.
- Host logic writes characters by address.
- A frame refresh starts on request, or automatically when the buffer is dirty.
- The byte handshake towards the controller is strobe/done.

Parameters:
LINE0_CMD, 8'h80, command byte (rs=0) sent before characters 0..15
LINE1_CMD, 8'hC0, command byte (rs=0) sent before characters 16..31
AUTO_REFRESH, 0, 1 = start a frame automatically whenever dirty=1 and the FSM is idle
FILL_CHAR, 8'h20, value loaded into every buffer entry on reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_en  in  1  host write strobe, one write per cycle
wr_addr  in  5  buffer index; 0..15 = line 0, 16..31 = line 1
wr_data  in  8  character code
rd_addr  in  5  readback index
rd_data  out  8  registered readback: buffer[rd_addr], one cycle latency
refresh_req  in  1  request a frame send; level sampled each cycle
busy  out  1  high from the frame-start cycle until the frame ends
frame_done  out  1  one-cycle pulse after the 34th byte completes
ctrl_data  out  8  byte to the controller
ctrl_rs  out  1  0 = command, 1 = character data
ctrl_strobe  out  1  one-cycle pulse presenting ctrl_data/ctrl_rs
ctrl_done  in  1  controller idle/ready; low during controller init and while a byte is in flight

Behaviour:
- Reset values:
  - busy, frame_done, ctrl_strobe, ctrl_rs, dirty and pending all 0.
  - ctrl_data and rd_data are 8'h00.
  - Every buffer entry is FILL_CHAR.
- Reset mid-frame aborts the frame immediately; no further strobes are issued.
- Buffer writes:
  - wr_en=1 writes buffer[wr_addr] <= wr_data at the clock edge and sets dirty.
  - Writes are accepted in every state, including during a frame.
- Pending request:
  - refresh_req=1 while busy sets a one-deep pending flag.
  - Extra requests during the same frame are merged into that flag.
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE:
  - Frame start occurs when ctrl_done=1 and any of these holds: refresh_req=1, pending=1, or (AUTO_REFRESH=1 and dirty=1).
  - On frame start: idx <= 0, busy <= 1, dirty <= 0, pending <= 0, go to SEND.
  - A write in the frame-start cycle sets dirty again; the write wins.
  - While ctrl_done=0 (controller initialising), the FSM stays in IDLE and the request stays latched.
- SEND (one cycle):
  - Registers ctrl_strobe=1 together with ctrl_data and ctrl_rs for the current idx:
    - idx 0: LINE0_CMD, rs=0.
    - idx 1..16: buffer[idx-1], rs=1.
    - idx 17: LINE1_CMD, rs=0.
    - idx 18..33: buffer[idx-2], rs=1.
  - The buffer is read in the SEND cycle, so a same-cycle write to that entry is not reflected until the next frame.
  - Go to WAIT_ACK.
- Controller contract: ctrl_done falls within the cycle after ctrl_strobe.
- WAIT_ACK:
  - ctrl_strobe=0.
  - Wait for ctrl_done=0, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for ctrl_done=1.
  - If idx==33, go to FINISH; otherwise idx <= idx+1 and go to SEND.
- FINISH (one cycle):
  - frame_done=1 and busy <= 0, then go to IDLE.
  - Back-to-back frames are possible: a pending request or dirty flag is evaluated in the following IDLE cycle.
- Strobe spacing: the minimum spacing between strobes is 4 cycles.
- Output stability: ctrl_data and ctrl_rs hold their value from one SEND until the next SEND.
- Index arithmetic:
  - idx is 6 bits and never exceeds 33.
  - wr_addr and rd_addr are 5 bits, covering the full 32-entry range; no out-of-range case exists.

Test Plan:
- Reset, then ctrl_done=1, then pulse refresh_req -> ctrl_strobe rises the cycle after the request is sampled. The 34-byte sequence is: 0x80 rs=0, 16x 0x20 rs=1, 0xC0 rs=0, 16x 0x20 rs=1. frame_done pulses once and busy falls.
- Write 0x41 at addr 0 and 0x5A at addr 31, then refresh -> byte 2 is 0x41 and byte 34 is 0x5A. rd_addr=31 returns 0x5A one cycle later.
- Hold ctrl_done=0 for 1000 cycles after reset with refresh_req pulsed -> no strobe during that time. The first strobe follows within 2 cycles of ctrl_done rising.
- Pulse refresh_req three times mid-frame -> exactly one further frame follows immediately, with frame_done pulsing twice in total.
- AUTO_REFRESH=1: write addr 20 = 0x33 mid-frame -> a second frame starts automatically. If the write lands before that entry's SEND (byte 23), it appears in the current frame and again in the next. With no further writes, no third frame occurs.
- Assert rst at byte 10 -> strobes stop at once, outputs return to 0, the buffer reads back 0x20, and busy=0.
